// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : Write-side front end for the register file. Merges load and
//               ALU results into an in-order FIFO and drains one entry per
//               cycle onto the registered write port (rc/dataC/w_en). Also
//               exports a mask of destinations that still have a write in
//               flight.
//               Optional build macro REG_WB_BYPASS_EN: when the FIFO is empty,
//               the first accepted result goes straight to the write port.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // load result channel
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [AW-1:0]           mem_rd,
    input  logic [DW-1:0]           mem_data,
    // ALU result channel
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [AW-1:0]           alu_rd,
    input  logic [DW-1:0]           alu_data,
    // register-file write port
    output logic [AW-1:0]           rc,
    output logic [DW-1:0]           dataC,
    output logic                    w_en,
    // hazard and status
    output logic [(1<<AW)-1:0]      pending,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = c_pw + 1;
    localparam int c_nr = 1 << AW;
    localparam logic [c_cw:0] c_depth_x = (c_cw + 1)'(DEPTH);

`ifdef REG_WB_BYPASS_EN
    localparam logic c_bypass_en = 1'b1;
`else
    localparam logic c_bypass_en = 1'b0;
`endif

    // FIFO storage and control state
    logic [AW-1:0]   r_fifo_rd   [DEPTH];
    logic [DW-1:0]   r_fifo_data [DEPTH];
    logic [c_pw-1:0] r_wptr;
    logic [c_pw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;

    // write-port registers
    logic [AW-1:0]   r_rc;
    logic [DW-1:0]   r_data_c;
    logic            r_w_en;

    // handshake and datapath steering
    logic [c_cw:0]   w_count_x;
    logic            w_push_mem;
    logic            w_push_alu;
    logic            w_pop;
    logic            w_bypass;
    logic            w_first_v;
    logic [AW-1:0]   w_first_rd;
    logic [DW-1:0]   w_first_data;
    logic            w_second_v;
    logic            w_enq0_v;
    logic [AW-1:0]   w_enq0_rd;
    logic [DW-1:0]   w_enq0_data;
    logic            w_enq1_v;
    logic [1:0]      w_n_enq;
    logic [c_pw-1:0] w_wptr_p1;
    logic [DEPTH-1:0] w_slot_live;
    logic [c_nr-1:0] w_pending;

    // Readies look only at the pre-edge occupancy; a same-cycle pop is ignored
    // so a full FIFO refuses input even while it drains.
    assign w_count_x  = {1'b0, r_count};
    assign mem_ready  = !rst && (w_count_x < c_depth_x);
    assign alu_ready  = !rst && ((w_count_x + {{c_cw{1'b0}}, mem_valid}) < c_depth_x);

    assign w_push_mem = mem_valid && mem_ready;
    assign w_push_alu = alu_valid && alu_ready;
    assign w_pop      = (r_count != '0);
    assign w_wptr_p1  = r_wptr + c_pw'(1);

    // Order same-cycle arrivals: load first, ALU second.
    always_comb begin
        w_first_v    = w_push_mem || w_push_alu;
        w_first_rd   = w_push_mem ? mem_rd   : alu_rd;
        w_first_data = w_push_mem ? mem_data : alu_data;
        w_second_v   = w_push_mem && w_push_alu;
    end

    // The bypass only fires when nothing is queued, so it never overtakes an
    // older entry and write order still equals acceptance order.
    assign w_bypass = c_bypass_en && !w_pop && w_first_v;

    // Select which results go into the FIFO this cycle and in what order.
    always_comb begin
        w_enq0_v    = 1'b0;
        w_enq0_rd   = w_first_rd;
        w_enq0_data = w_first_data;
        w_enq1_v    = 1'b0;
        if (w_bypass) begin
            // first result went to the port; the ALU result (if any) queues
            w_enq0_v    = w_second_v;
            w_enq0_rd   = alu_rd;
            w_enq0_data = alu_data;
        end else begin
            w_enq0_v    = w_first_v;
            w_enq1_v    = w_second_v;
        end
    end

    assign w_n_enq = {1'b0, w_enq0_v} + {1'b0, w_enq1_v};

    // FIFO payload storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_enq0_v) begin
            r_fifo_rd[r_wptr]   <= w_enq0_rd;
            r_fifo_data[r_wptr] <= w_enq0_data;
        end
        if (w_enq1_v) begin
            r_fifo_rd[w_wptr_p1]   <= alu_rd;
            r_fifo_data[w_wptr_p1] <= alu_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + c_pw'(w_n_enq);
            r_rptr  <= r_rptr + c_pw'(w_pop);
            r_count <= r_count + c_cw'(w_n_enq) - c_cw'(w_pop);
        end
    end

    // Write-port registers: head of FIFO, else bypassed result, else idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_en   <= 1'b0;
            r_rc     <= '0;
            r_data_c <= '0;
        end else if (w_pop) begin
            r_w_en   <= 1'b1;
            r_rc     <= r_fifo_rd[r_rptr];
            r_data_c <= r_fifo_data[r_rptr];
        end else if (w_bypass) begin
            r_w_en   <= 1'b1;
            r_rc     <= w_first_rd;
            r_data_c <= w_first_data;
        end else begin
            r_w_en   <= 1'b0;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [c_pw-1:0] w_off;
            assign w_off          = c_pw'(i) - r_rptr;
            assign w_slot_live[i] = ({1'b0, w_off} < r_count);
        end
    endgenerate

    // Pending mask from state only: live FIFO entries plus the write port.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_live[i]) begin
                w_pending[r_fifo_rd[i]] = 1'b1;
            end
        end
        if (r_w_en) begin
            w_pending[r_rc] = 1'b1;
        end
    end

    assign pending = w_pending;
    assign count   = r_count;
    assign rc      = r_rc;
    assign dataC   = r_data_c;
    assign w_en    = r_w_en;

endmodule
`default_nettype wire
